// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch and data-memory requesters, the port arbiter
// and the single-port unified memory.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  // Arbiter side: takes requests and memory read data, returns acks and drives the memory.
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_rdata, if_ack, dm_rdata, dm_ack,
    output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );

  // Environment side: the pipeline stages plus the memory model.
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// the data-memory stage. One access in flight at a time; data has priority
// unless fetch has lost STARVE_MAX grants in a row while waiting.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] LAT_INIT   = 4'(MEM_LAT);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t            state_q;
  logic              owner_dm_q;
  logic              store_q;
  logic [3:0]        cnt_q;
  logic [3:0]        starve_q;
  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_ack_q;
  logic              dm_ack_q;

  logic              grant_dm_d;
  logic [3:0]        starve_d;

  // Winner selection and the starve count that goes with it, used only when a grant is made.
  always_comb begin
    grant_dm_d = bus.dm_req & ~(bus.if_req & (starve_q == STARVE_LIM));
    starve_d   = 4'd0;
    if (grant_dm_d && bus.if_req) begin
      starve_d = (starve_q == 4'd15) ? 4'd15 : starve_q + 4'd1;
    end
  end

  // Port sequencer: grant in IDLE, count down the memory latency in ACCESS, hold the ack for one RESP cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      owner_dm_q  <= 1'b0;
      store_q     <= 1'b0;
      cnt_q       <= 4'd0;
      starve_q    <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.if_req || bus.dm_req) begin
            owner_dm_q <= grant_dm_d;
            store_q    <= grant_dm_d & bus.dm_we;
            mem_we_q   <= grant_dm_d & bus.dm_we;
            mem_addr_q <= grant_dm_d ? bus.dm_addr : bus.if_addr;
            if (grant_dm_d) begin
              mem_wdata_q <= bus.dm_wdata;
            end
            mem_en_q <= 1'b1;
            cnt_q    <= LAT_INIT;
            starve_q <= starve_d;
            state_q  <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          cnt_q    <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (!owner_dm_q) begin
              if_rdata_q <= bus.mem_rdata;
              if_ack_q   <= 1'b1;
            end else begin
              if (!store_q) begin
                dm_rdata_q <= bus.mem_rdata;
              end
              dm_ack_q <= 1'b1;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          if_ack_q <= 1'b0;
          dm_ack_q <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.stall_if  = bus.if_req & ~if_ack_q;
  assign bus.stall_mem = bus.dm_req & ~dm_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: main instance at MEM_LAT=2/STARVE_MAX=3,
// a second instance at MEM_LAT=1/STARVE_MAX=1 for the lower bounds.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus2 ();

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2), .STARVE_MAX(3)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(1)) dut2 (
    .clk(clk),
    .rst(rst),
    .bus(bus2)
  );

  // Memory model for the main instance; stores are written from the step task.
  logic [15:0] memArr [0:4095];
  assign bus.mem_rdata  = memArr[bus.mem_addr[11:0]];
  // Second instance reads a fixed function of the address.
  assign bus2.mem_rdata = bus2.mem_addr ^ 16'h5555;

  // {mem_en, mem_we, if_ack, dm_ack, stall_if, stall_mem}
  logic [5:0] flagsA;
  logic [5:0] flagsB;
  assign flagsA = {bus.mem_en, bus.mem_we, bus.if_ack, bus.dm_ack, bus.stall_if, bus.stall_mem};
  assign flagsB = {bus2.mem_en, bus2.mem_we, bus2.if_ack, bus2.dm_ack, bus2.stall_if, bus2.stall_mem};

  typedef struct {
    bit          ifReq;
    bit          dmReq;
    bit          dmWe;
    bit          preload;
    bit          expDmFirst;
    logic [15:0] ifAddr;
    logic [15:0] dmAddr;
    logic [15:0] dmWdata;
    logic [15:0] ifMem;
    logic [15:0] dmMem;
    logic [15:0] expIfRdata;
    logic [15:0] expDmRdata;
  } vec_t;

  vec_t        vecs [7];
  vec_t        v0;
  vec_t        vs;
  int          nCompared = 0;
  int          nMismatch = 0;
  logic [15:0] prevIf;
  logic [15:0] prevDm;

  function automatic vec_t mkVec(input bit ifReq, input bit dmReq, input bit dmWe,
                                 input bit preload, input bit dmFirst,
                                 input logic [15:0] ifAddr, input logic [15:0] dmAddr,
                                 input logic [15:0] dmWdata, input logic [15:0] ifMem,
                                 input logic [15:0] dmMem, input logic [15:0] expIf,
                                 input logic [15:0] expDm);
    vec_t v;
    v.ifReq      = ifReq;
    v.dmReq      = dmReq;
    v.dmWe       = dmWe;
    v.preload    = preload;
    v.expDmFirst = dmFirst;
    v.ifAddr     = ifAddr;
    v.dmAddr     = dmAddr;
    v.dmWdata    = dmWdata;
    v.ifMem      = ifMem;
    v.dmMem      = dmMem;
    v.expIfRdata = expIf;
    v.expDmRdata = expDm;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle; the memory model commits any store strobed in the current cycle.
  task automatic step();
    if (bus.mem_en === 1'b1 && bus.mem_we === 1'b1) begin
      memArr[bus.mem_addr[11:0]] = bus.mem_wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    if (v.preload) begin
      if (v.ifReq) memArr[v.ifAddr[11:0]] = v.ifMem;
      if (v.dmReq && !v.dmWe) memArr[v.dmAddr[11:0]] = v.dmMem;
    end
    bus.if_req   = v.ifReq;
    bus.if_addr  = v.ifAddr;
    bus.dm_req   = v.dmReq;
    bus.dm_we    = v.dmWe;
    bus.dm_addr  = v.dmAddr;
    bus.dm_wdata = v.dmWdata;
  endtask

  // Walk one vector cycle by cycle from the first sampling edge until the port is idle again.
  task automatic checkVec(input int idx, input vec_t v);
    bit          both;
    bit          firstDm;
    bit          enDm;
    bit          expEn;
    bit          expWe;
    int          ifAck;
    int          dmAck;
    int          lastAck;
    logic [5:0]  expFlags;
    logic [15:0] expAddr;
    both    = v.ifReq && v.dmReq;
    firstDm = v.dmReq && (!v.ifReq || v.expDmFirst);
    ifAck   = !v.ifReq ? 0 : (firstDm ? 7 : 3);
    dmAck   = !v.dmReq ? 0 : (firstDm ? 3 : 7);
    lastAck = (ifAck > dmAck) ? ifAck : dmAck;
    for (int c = 1; c <= lastAck + 1; c++) begin
      step();
      enDm     = (c < 5) ? firstDm : !firstDm;
      expEn    = (c == 1) || (both && c == 5);
      expWe    = expEn && enDm && v.dmWe;
      expAddr  = enDm ? v.dmAddr : v.ifAddr;
      expFlags = {expEn, expWe, c == ifAck, c == dmAck, v.ifReq && c < ifAck, v.dmReq && c < dmAck};
      if (c == ifAck) prevIf = v.expIfRdata;
      if (c == dmAck) prevDm = v.expDmRdata;
      checkOutput($sformatf("vec%0d c%0d flags", idx, c), 16'(flagsA), 16'(expFlags));
      checkOutput($sformatf("vec%0d c%0d mem_addr", idx, c), bus.mem_addr, expAddr);
      if (expWe) checkOutput($sformatf("vec%0d c%0d mem_wdata", idx, c), bus.mem_wdata, v.dmWdata);
      checkOutput($sformatf("vec%0d c%0d if_rdata", idx, c), bus.if_rdata, prevIf);
      checkOutput($sformatf("vec%0d c%0d dm_rdata", idx, c), bus.dm_rdata, prevDm);
      if (c == 2) begin
        if (firstDm) begin
          bus.dm_addr  = ~v.dmAddr;
          bus.dm_wdata = ~v.dmWdata;
        end else begin
          bus.if_addr = ~v.ifAddr;
        end
      end
      if (c == ifAck) bus.if_req = 1'b0;
      if (c == dmAck) bus.dm_req = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          isIf;
    bit          ackNow;
    int          k;
    int          ph;
    logic [7:0]  pattern;
    logic [5:0]  expFlags;

    bus2.if_req   = 1'b0;
    bus2.if_addr  = 16'h0;
    bus2.dm_req   = 1'b0;
    bus2.dm_we    = 1'b0;
    bus2.dm_addr  = 16'h0;
    bus2.dm_wdata = 16'h0;

    v0 = mkVec(1, 1, 0, 1, 1, 16'h0008, 16'h0100, 16'h0000, 16'h0808, 16'h0101, 16'h0808, 16'h0101);
    vecs[0] = mkVec(1, 0, 0, 1, 0, 16'h0010, 16'h0000, 16'h0000, 16'hA5A5, 16'h0000, 16'hA5A5, 16'h0101);
    vecs[1] = mkVec(1, 1, 0, 1, 1, 16'h0020, 16'h0200, 16'h0000, 16'h1111, 16'h1234, 16'h1111, 16'h1234);
    vecs[2] = mkVec(0, 1, 1, 0, 1, 16'h0000, 16'h0300, 16'hBEEF, 16'h0000, 16'h0000, 16'h1111, 16'h1234);
    vecs[3] = mkVec(0, 1, 0, 0, 1, 16'h0000, 16'h0300, 16'h0000, 16'h0000, 16'h0000, 16'h1111, 16'hBEEF);
    vecs[4] = mkVec(1, 1, 1, 1, 1, 16'h0030, 16'h0400, 16'h5A5A, 16'h0F0F, 16'h0000, 16'h0F0F, 16'hBEEF);
    vecs[5] = mkVec(1, 0, 0, 0, 0, 16'h0400, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h5A5A, 16'hBEEF);
    vecs[6] = mkVec(1, 0, 0, 1, 0, 16'hFFF0, 16'h0000, 16'h0000, 16'h7E7E, 16'h0000, 16'h7E7E, 16'hBEEF);

    // Reset held with both requests pending, then released.
    applyStimulus(v0);
    #2 rst = 1'b0;
    step();
    step();
    checkOutput("reset flags", 16'(flagsA), 16'(6'b000011));
    checkOutput("reset mem_addr", bus.mem_addr, 16'h0000);
    checkOutput("reset mem_wdata", bus.mem_wdata, 16'h0000);
    checkOutput("reset if_rdata", bus.if_rdata, 16'h0000);
    checkOutput("reset dm_rdata", bus.dm_rdata, 16'h0000);
    checkOutput("reset dut2 flags", 16'(flagsB), 16'(6'b000000));
    rst    = 1'b1;
    prevIf = 16'h0000;
    prevDm = 16'h0000;
    checkVec(100, v0);

    // Table of single and paired transactions.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      checkVec(i, vecs[i]);
    end

    // Starvation: both requests held; grant order D D D I D D D I.
    applyStimulus(mkVec(1, 1, 0, 1, 1, 16'h0040, 16'h0050, 16'h0000, 16'h4444, 16'h5555, 16'h0, 16'h0));
    pattern = 8'b1000_1000;
    for (int c = 1; c <= 31; c++) begin
      step();
      k      = (c - 1) / 4;
      ph     = (c - 1) % 4;
      isIf   = pattern[k];
      ackNow = (ph == 2);
      expFlags = {ph == 0, 1'b0, ackNow && isIf, ackNow && !isIf, !(ackNow && isIf), !(ackNow && !isIf)};
      if (ackNow && isIf) prevIf = 16'h4444;
      if (ackNow && !isIf) prevDm = 16'h5555;
      checkOutput($sformatf("starve c%0d flags", c), 16'(flagsA), 16'(expFlags));
      checkOutput($sformatf("starve c%0d mem_addr", c), bus.mem_addr, isIf ? 16'h0040 : 16'h0050);
      checkOutput($sformatf("starve c%0d if_rdata", c), bus.if_rdata, prevIf);
      checkOutput($sformatf("starve c%0d dm_rdata", c), bus.dm_rdata, prevDm);
      if (c == 31) begin
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
      end
    end
    step();
    checkOutput("starve idle flags", 16'(flagsA), 16'(6'b000000));

    // Reset in the second ACCESS cycle of a fetch; the held request is re-served in full.
    vs = mkVec(1, 0, 0, 1, 0, 16'h0060, 16'h0000, 16'h0000, 16'h3C3C, 16'h0000, 16'h3C3C, 16'h0000);
    applyStimulus(vs);
    step();
    checkOutput("midreset c1 flags", 16'(flagsA), 16'(6'b100010));
    step();
    rst = 1'b0;
    #1;
    checkOutput("midreset async flags", 16'(flagsA), 16'(6'b000010));
    checkOutput("midreset mem_addr", bus.mem_addr, 16'h0000);
    checkOutput("midreset if_rdata", bus.if_rdata, 16'h0000);
    checkOutput("midreset dm_rdata", bus.dm_rdata, 16'h0000);
    step();
    step();
    checkOutput("midreset held flags", 16'(flagsA), 16'(6'b000010));
    rst    = 1'b1;
    prevIf = 16'h0000;
    prevDm = 16'h0000;
    bus.if_addr = vs.ifAddr;
    checkVec(200, vs);

    // Reset while the ack is showing: ack drops at once and nothing is retried.
    applyStimulus(mkVec(1, 0, 0, 1, 0, 16'h0070, 16'h0000, 16'h0000, 16'h7070, 16'h0000, 16'h0, 16'h0));
    step();
    step();
    step();
    checkOutput("respreset ack flags", 16'(flagsA), 16'(6'b001000));
    checkOutput("respreset ack if_rdata", bus.if_rdata, 16'h7070);
    rst = 1'b0;
    #1;
    checkOutput("respreset async flags", 16'(flagsA), 16'(6'b000010));
    checkOutput("respreset if_rdata", bus.if_rdata, 16'h0000);
    bus.if_req = 1'b0;
    step();
    rst = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      step();
      checkOutput($sformatf("respreset idle c%0d flags", c), 16'(flagsA), 16'(6'b000000));
    end

    // MEM_LAT=1 instance: strobe and capture in one ACCESS cycle.
    bus2.if_req  = 1'b1;
    bus2.if_addr = 16'h1234;
    step();
    checkOutput("lat1 c1 flags", 16'(flagsB), 16'(6'b100010));
    checkOutput("lat1 c1 mem_addr", bus2.mem_addr, 16'h1234);
    step();
    checkOutput("lat1 c2 flags", 16'(flagsB), 16'(6'b001000));
    checkOutput("lat1 c2 if_rdata", bus2.if_rdata, 16'h4761);
    bus2.if_req = 1'b0;
    step();
    checkOutput("lat1 c3 flags", 16'(flagsB), 16'(6'b000000));

    // STARVE_MAX=1: fetch and data alternate D I D I.
    bus2.if_req  = 1'b1;
    bus2.if_addr = 16'h0100;
    bus2.dm_req  = 1'b1;
    bus2.dm_addr = 16'h2000;
    for (int c = 1; c <= 11; c++) begin
      step();
      k      = (c - 1) / 3;
      ph     = (c - 1) % 3;
      isIf   = (k % 2 == 1);
      ackNow = (ph == 1);
      expFlags = {ph == 0, 1'b0, ackNow && isIf, ackNow && !isIf, !(ackNow && isIf), !(ackNow && !isIf)};
      checkOutput($sformatf("alt c%0d flags", c), 16'(flagsB), 16'(expFlags));
      checkOutput($sformatf("alt c%0d mem_addr", c), bus2.mem_addr, isIf ? 16'h0100 : 16'h2000);
      if (ackNow && isIf) checkOutput($sformatf("alt c%0d if_rdata", c), bus2.if_rdata, 16'h5455);
      if (ackNow && !isIf) checkOutput($sformatf("alt c%0d dm_rdata", c), bus2.dm_rdata, 16'h7555);
      if (c == 11) begin
        bus2.if_req = 1'b0;
        bus2.dm_req = 1'b0;
      end
    end
    step();
    checkOutput("alt idle flags", 16'(flagsB), 16'(6'b000000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch stage and the data-memory stage of the pipelined CPU.
- Arbitrates between the fetch requester and the load/store requester.
- Sequences each access through a fixed-latency memory.
- Returns read data and a one-cycle acknowledge to the requester that was served.
- Drives stall_if and stall_mem into the hazard-detection and PC logic, so the pipeline stalls while a stage waits for the port.

Parameters:
ADDR_W, 16, address width of both requesters and the memory.
DATA_W, 16, data width.
MEM_LAT, 2, cycles from the mem_en cycle to the ack cycle; legal range 1..15.
STARVE_MAX, 3, consecutive data grants made while if_req is pending before fetch is forced to win; legal range 1..15.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset.
if_req  input  1  fetch request; held until if_ack.
if_addr  input  ADDR_W  fetch address; stable while if_req is high.
if_rdata  output  DATA_W  fetched instruction; valid when if_ack=1, then held.
if_ack  output  1  one-cycle completion pulse for fetch.
dm_req  input  1  data request; held until dm_ack.
dm_we  input  1  1 = store, 0 = load.
dm_addr  input  ADDR_W  data address.
dm_wdata  input  DATA_W  store data.
dm_rdata  output  DATA_W  load data; valid when dm_ack=1, then held.
dm_ack  output  1  one-cycle completion pulse for data.
mem_en  output  1  one-cycle access strobe to memory.
mem_we  output  1  write enable; qualified by mem_en.
mem_addr  output  ADDR_W  latched access address.
mem_wdata  output  DATA_W  latched store data.
mem_rdata  input  DATA_W  memory read data; valid in the last ACCESS cycle (cnt==1).
stall_if  output  1  if_req & ~if_ack (combinational).
stall_mem  output  1  dm_req & ~dm_ack (combinational).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; owner=IF; cnt=0; starve=0.
  - mem_en, mem_we, if_ack and dm_ack are 0.
  - mem_addr, mem_wdata, if_rdata and dm_rdata are 0.
  - An access in flight is abandoned. No ack is issued for it, and mem_en drops immediately.
- FSM states are IDLE, ACCESS and RESP. The FSM is single-outstanding: exactly one access at a time.
- IDLE:
  - No request: stay in IDLE.
  - Request present: at the edge, choose the winner, then:
    - latch owner and mem_addr;
    - if the winner is data, latch mem_wdata and set mem_we=dm_we, else mem_we=0;
    - mem_en<=1; cnt<=MEM_LAT; state<=ACCESS.
- Priority:
  - Data wins over fetch.
  - Exception: fetch wins if if_req=1 and starve==STARVE_MAX.
- Starve counter:
  - Increments (saturating at 15) on a data grant made while if_req=1.
  - Clears on a fetch grant, and on a data grant made while if_req=0.
- ACCESS:
  - mem_en and mem_we are high only in the first ACCESS cycle; they are registered to 0 at the next edge.
  - cnt decrements every edge.
  - At the edge where cnt==1:
    - if owner is IF, capture mem_rdata into if_rdata and set if_ack<=1;
    - if owner is DM and it is a load, capture mem_rdata into dm_rdata and set dm_ack<=1;
    - if owner is DM and it is a store, set dm_ack<=1 and leave dm_rdata unchanged;
    - state<=RESP.
- RESP:
  - The ack is high for exactly this cycle.
  - No grant is made in RESP, and requests are ignored.
  - At the next edge the ack clears and state<=IDLE.
  - The served requester must drop req in the cycle after the ack. A req still high in IDLE is a new request.
- Latency:
  - Request sampled in IDLE at edge E: mem_en is high in cycle E+1.
  - The ack is high in cycle E+MEM_LAT+1.
  - Port occupancy is MEM_LAT+2 cycles per access.
- MEM_LAT=1: a single ACCESS cycle (mem_en and rdata capture in the same cycle).
- A losing requester keeps its stall asserted and is granted at the next IDLE, subject to priority.
- Requester-side changes to address or data after the grant have no effect on the access in flight, because they are latched.
- Reset during RESP: the ack drops immediately and no retry is made.

Test Plan:
- Reset: hold rst=0 with both reqs high -> mem_en=0, both acks 0, stall_if=1, stall_mem=1. Release -> the data grant occurs at the first edge.
- Single fetch, MEM_LAT=2:
  - Stimulus: if_req at edge 0, addr=0x0010; memory returns 0xA5A5.
  - Response: mem_en and mem_addr=0x0010 in cycle 1; if_ack with if_rdata=0xA5A5 in cycle 3; stall_if drops in cycle 3.
- Simultaneous if_req and dm_req (load 0x0200 -> 0x1234):
  - Data is served first: dm_ack in cycle 3, dm_rdata=0x1234.
  - Fetch mem_en follows in cycle 5; if_ack in cycle 7.
- Starvation, STARVE_MAX=3, dm_req continuously re-asserted, if_req held: the grant order is DM, DM, DM, IF, DM...; starve returns to 0 after the IF grant.
- Store: dm_we=1, addr=0x0300, wdata=0xBEEF -> single-cycle mem_en with mem_we=1, mem_addr=0x0300, mem_wdata=0xBEEF; dm_ack in cycle 3; dm_rdata unchanged.
- Reset mid-ACCESS: assert rst=0 in cycle 2 of a fetch -> no if_ack; state is IDLE on release; the same pending if_req is re-served with full latency.
